// File: rtl/enemy_life_ctrl_pkg.sv
// Shared definitions for the enemy lifecycle controller: slot state codes,
// frame-select codes and per-class tuning values.
package enemy_life_ctrl_pkg;

    typedef enum logic [1:0] {
        ELC_UNVISUAL = 2'd0,
        ELC_NORMAL   = 2'd1,
        ELC_HIT      = 2'd2,
        ELC_DOWN     = 2'd3
    } elc_state_e;

    localparam int FRAME_NORMAL    = 0;
    localparam int FRAME_HIT       = 1;
    localparam int FRAME_DOWN_BASE = 2;

    typedef enum logic [1:0] {
        ELC_CLASS_SMALL  = 2'd0,
        ELC_CLASS_MEDIUM = 2'd1,
        ELC_CLASS_BOSS   = 2'd2
    } elc_class_e;

    typedef struct packed {
        int max_hp;
        int down_frames;
        int tick_period;
    } elc_class_cfg_t;

    // Tuning table used when instantiating the controller for each enemy class.
    function automatic elc_class_cfg_t elc_class_cfg(input elc_class_e cls);
        elc_class_cfg_t cfg;
        cfg.max_hp      = 3;
        cfg.down_frames = 3;
        cfg.tick_period = 2500000;
        case (cls)
            ELC_CLASS_SMALL: begin
                cfg.max_hp      = 1;
                cfg.down_frames = 2;
            end
            ELC_CLASS_BOSS: begin
                cfg.max_hp      = 15;
                cfg.down_frames = 5;
                cfg.tick_period = 5000000;
            end
            default: ;
        endcase
        return cfg;
    endfunction

endpackage

// File: rtl/enemy_life_slot.sv
// One enemy slot: life FSM with hit points, hit-flash timer and destruction frame counter.
module enemy_life_slot
    import enemy_life_ctrl_pkg::*;
#(
    parameter int MAX_HP        = 3,
    parameter int HP_BIT_LEN    = 4,
    parameter int DOWN_FRAMES   = 3,
    parameter int FRAME_BIT_LEN = 3,
    parameter int HIT_TICKS     = 1
) (
    input  logic                     clk_vga,
    input  logic                     rst,
    input  logic                     en_i,
    input  logic                     tick_i,
    input  logic                     trigger_i,
    input  logic                     bullet_i,
    input  logic                     player_i,
    output logic [1:0]               state_o,
    output logic [FRAME_BIT_LEN-1:0] dframe_o,
    output logic                     destroy_o,
    output logic                     killed_by_me_o
);

    localparam int FLASH_W = (HIT_TICKS < 2) ? 1 : $clog2(HIT_TICKS + 1);

    elc_state_e               state, state_nxt;
    logic [HP_BIT_LEN-1:0]    hp, hp_nxt;
    logic [FLASH_W-1:0]       flash, flash_nxt;
    logic [FRAME_BIT_LEN-1:0] dframe, dframe_nxt;
    logic                     live;
    logic                     fatal;

    assign live  = (state == ELC_NORMAL) || (state == ELC_HIT);
    // Player contact always kills; a bullet kills only on the last hit point.
    assign fatal = en_i && live && (player_i || (bullet_i && (hp == HP_BIT_LEN'(1))));

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state  <= ELC_UNVISUAL;
            hp     <= '0;
            flash  <= '0;
            dframe <= '0;
        end else begin
            state  <= state_nxt;
            hp     <= hp_nxt;
            flash  <= flash_nxt;
            dframe <= dframe_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        hp_nxt     = hp;
        flash_nxt  = flash;
        dframe_nxt = dframe;
        if (en_i) begin
            case (state)
                ELC_UNVISUAL: begin
                    if (trigger_i) begin
                        state_nxt  = ELC_NORMAL;
                        hp_nxt     = HP_BIT_LEN'(MAX_HP);
                        flash_nxt  = '0;
                        dframe_nxt = '0;
                    end
                end
                ELC_NORMAL, ELC_HIT: begin
                    if (fatal) begin
                        state_nxt  = ELC_DOWN;
                        dframe_nxt = '0;
                        flash_nxt  = '0;
                    end else if (bullet_i) begin
                        state_nxt = ELC_HIT;
                        hp_nxt    = hp - HP_BIT_LEN'(1);
                        flash_nxt = FLASH_W'(HIT_TICKS);
                    end else if (state == ELC_HIT && tick_i) begin
                        if (flash <= FLASH_W'(1)) begin
                            state_nxt = ELC_NORMAL;
                            flash_nxt = '0;
                        end else begin
                            flash_nxt = flash - FLASH_W'(1);
                        end
                    end
                end
                ELC_DOWN: begin
                    if (tick_i) begin
                        if (dframe == FRAME_BIT_LEN'(DOWN_FRAMES - 1)) begin
                            state_nxt  = ELC_UNVISUAL;
                            hp_nxt     = '0;
                            dframe_nxt = '0;
                        end else begin
                            dframe_nxt = dframe + FRAME_BIT_LEN'(1);
                        end
                    end
                end
                default: state_nxt = ELC_UNVISUAL;
            endcase
        end
    end

    always_comb begin
        state_o        = state;
        dframe_o       = dframe;
        destroy_o      = fatal;
        killed_by_me_o = fatal && player_i;
    end

endmodule

// File: rtl/enemy_life_ctrl.sv
// Per-slot enemy lifecycle controller: animation tick, crash routing, pixel-time
// frame/visibility mux and the registered destroy event used for scoring.
module enemy_life_ctrl
    import enemy_life_ctrl_pkg::*;
#(
    parameter int ENEMY_NUM         = 4,
    parameter int ENEMY_NUM_BIT_LEN = 2,
    parameter int MAX_HP            = 3,
    parameter int HP_BIT_LEN        = 4,
    parameter int DOWN_FRAMES       = 3,
    parameter int FRAME_BIT_LEN     = 3,
    parameter int TICK_PERIOD       = 2500000,
    parameter int TICK_BIT_LEN      = 22,
    parameter int HIT_TICKS         = 1
) (
    input  logic                         clk_vga,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         enemy_vali_i,
    input  logic [ENEMY_NUM_BIT_LEN-1:0] curr_enemy_idx_i,
    input  logic                         crash_enemy_bullet_i,
    input  logic                         crash_me_enemy_i,
    input  logic                         trigger_i,
    input  logic [ENEMY_NUM_BIT_LEN-1:0] trigger_idx_i,
    output logic [ENEMY_NUM-1:0]         disappear_o,
    output logic                         vis_o,
    output logic [FRAME_BIT_LEN-1:0]     frame_sel_o,
    output logic                         destroy_o,
    output logic [ENEMY_NUM_BIT_LEN-1:0] destroy_idx_o,
    output logic                         killed_by_me_o
);

    logic [TICK_BIT_LEN-1:0]  tick_cnt;
    logic                     tick;
    logic                     accept;
    logic [1:0]               slot_state  [ENEMY_NUM];
    logic [FRAME_BIT_LEN-1:0] slot_dframe [ENEMY_NUM];
    logic [ENEMY_NUM-1:0]     slot_destroy;
    logic [ENEMY_NUM-1:0]     slot_killed;

    assign tick   = en_i && (tick_cnt == TICK_BIT_LEN'(TICK_PERIOD - 1));
    assign accept = enemy_vali_i && (32'(curr_enemy_idx_i) < 32'(ENEMY_NUM));

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (en_i) begin
            tick_cnt <= tick ? '0 : tick_cnt + TICK_BIT_LEN'(1);
        end
    end

    for (genvar g = 0; g < ENEMY_NUM; g++) begin : g_slot
        logic hit_here;
        assign hit_here = accept && (curr_enemy_idx_i == ENEMY_NUM_BIT_LEN'(g));

        enemy_life_slot #(
            .MAX_HP        (MAX_HP),
            .HP_BIT_LEN    (HP_BIT_LEN),
            .DOWN_FRAMES   (DOWN_FRAMES),
            .FRAME_BIT_LEN (FRAME_BIT_LEN),
            .HIT_TICKS     (HIT_TICKS)
        ) u_slot (
            .clk_vga        (clk_vga),
            .rst            (rst),
            .en_i           (en_i),
            .tick_i         (tick),
            .trigger_i      (trigger_i && (trigger_idx_i == ENEMY_NUM_BIT_LEN'(g))),
            .bullet_i       (hit_here && crash_enemy_bullet_i),
            .player_i       (hit_here && crash_me_enemy_i),
            .state_o        (slot_state[g]),
            .dframe_o       (slot_dframe[g]),
            .destroy_o      (slot_destroy[g]),
            .killed_by_me_o (slot_killed[g])
        );

        assign disappear_o[g] = (slot_state[g] == ELC_UNVISUAL);
    end

    // Only the slot under the raster can be crashed, so at most one destroy bit is set.
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            destroy_o      <= 1'b0;
            destroy_idx_o  <= '0;
            killed_by_me_o <= 1'b0;
        end else begin
            destroy_o <= |slot_destroy;
            if (|slot_destroy) begin
                destroy_idx_o  <= curr_enemy_idx_i;
                killed_by_me_o <= |slot_killed;
            end
        end
    end

    always_comb begin
        vis_o       = 1'b0;
        frame_sel_o = FRAME_BIT_LEN'(FRAME_NORMAL);
        if (accept) begin
            case (elc_state_e'(slot_state[curr_enemy_idx_i]))
                ELC_NORMAL: vis_o = 1'b1;
                ELC_HIT: begin
                    vis_o       = 1'b1;
                    frame_sel_o = FRAME_BIT_LEN'(FRAME_HIT);
                end
                ELC_DOWN: begin
                    vis_o       = 1'b1;
                    frame_sel_o = FRAME_BIT_LEN'(FRAME_DOWN_BASE) + slot_dframe[curr_enemy_idx_i];
                end
                default: ;
            endcase
        end
    end

endmodule
